quad_step_decoder: RTL and testbench

- Decodes a 2-channel quadrature (A/B) position signal into the step-enable and direction strobes that drive the team's up/down limit counter.
- step_o connects to the counter's en_i and dir_o to its direction_i.
- Sits at the sensor boundary. It synchronises and glitch-filters the raw pins, decodes x4 (one step per valid edge), and flags illegal double transitions.

---
 rtl/quad_step_pkg.sv | 24 ++
 rtl/quad_step_decoder_if.sv | 25 ++
 rtl/qsd_chan_filter.sv | 47 ++++
 rtl/quad_step_decoder.sv | 88 ++++++++
 tb/tb_quad_step_decoder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_step_pkg.sv
// rtl/quad_step_pkg.sv - shared quadrature state type, state constants and forward-successor helper
package quad_step_pkg;

    typedef logic [1:0] quad_state_t;

    // Filtered channel pair packed as {A,B}
    localparam quad_state_t QS_00 = 2'b00;
    localparam quad_state_t QS_10 = 2'b10;
    localparam quad_state_t QS_11 = 2'b11;
    localparam quad_state_t QS_01 = 2'b01;

    // Forward (A leads B) successor; the reverse test is fwd_next(new) == prev
    function automatic quad_state_t fwd_next(input quad_state_t s);
        quad_state_t n;
        case (s)
            QS_00:   n = QS_10;
            QS_10:   n = QS_11;
            QS_11:   n = QS_01;
            default: n = QS_00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// rtl/quad_step_decoder_if.sv - control and strobe bundle between the decoder and its consumer
interface quad_step_decoder_if;
    import quad_step_pkg::*;

    logic        en_i;
    logic        clr_err_i;
    logic        step_o;
    logic        dir_o;
    logic        err_o;
    logic        err_sticky_o;
    quad_state_t ab_o;

    // Decoder side
    modport slave (
        input  en_i, clr_err_i,
        output step_o, dir_o, err_o, err_sticky_o, ab_o
    );

    // Consumer side (limit counter / register block)
    modport master (
        output en_i, clr_err_i,
        input  step_o, dir_o, err_o, err_sticky_o, ab_o
    );

endinterface

// File: rtl/qsd_chan_filter.sv
// rtl/qsd_chan_filter.sv - one-channel synchroniser followed by a persistence glitch filter
module qsd_chan_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int FILT_W      = $clog2(FILTER_LEN + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_raw,
    output logic o_filt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic [FILT_W-1:0]      r_cnt;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_filt = r_filt;

    // Plain flop chain into the clock domain; nothing may sit between stages
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Accept a new level only after it has disagreed for FILTER_LEN consecutive cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (w_sync != r_filt) begin
            if (r_cnt == FILT_W'(FILTER_LEN - 1)) begin
                r_filt <= w_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - x4 quadrature decoder producing step/direction strobes and illegal-transition flags
module quad_step_decoder
    import quad_step_pkg::*;
#(
    parameter  int SYNC_STAGES = 2,
    parameter  int FILTER_LEN  = 4,
    localparam int FILT_W      = $clog2(FILTER_LEN + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 a_i,
    input  logic                 b_i,
    quad_step_decoder_if.slave   qsd_bus
);

    logic        w_filt_a;
    logic        w_filt_b;
    quad_state_t w_new;
    logic        w_fwd;
    logic        w_rev;
    logic        w_err;

    quad_state_t r_prev;
    logic        r_step;
    logic        r_dir;
    logic        r_err;
    logic        r_sticky;

    qsd_chan_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .FILT_W      (FILT_W)
    ) u_filt_a (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_raw  (a_i),
        .o_filt (w_filt_a)
    );

    qsd_chan_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .FILT_W      (FILT_W)
    ) u_filt_b (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_raw  (b_i),
        .o_filt (w_filt_b)
    );

    assign w_new = {w_filt_a, w_filt_b};

    // Classify the filtered state change; equal states match neither neighbour test
    always_comb begin
        w_fwd = (fwd_next(r_prev) == w_new);
        w_rev = (fwd_next(w_new) == r_prev);
        w_err = ((w_new ^ r_prev) == 2'b11);
    end

    // Registered strobes; prev always follows so re-enabling never replays an old edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prev   <= QS_00;
            r_step   <= 1'b0;
            r_err    <= 1'b0;
            r_dir    <= 1'b1;
            r_sticky <= 1'b0;
        end else begin
            r_prev <= w_new;
            r_step <= qsd_bus.en_i & (w_fwd | w_rev);
            r_err  <= qsd_bus.en_i & w_err;
            if (qsd_bus.en_i && w_fwd) begin
                r_dir <= 1'b1;
            end else if (qsd_bus.en_i && w_rev) begin
                r_dir <= 1'b0;
            end
            // Set from both the incoming and the visible error so a clear overlapping err_o loses
            r_sticky <= (qsd_bus.en_i & w_err) | r_err | (r_sticky & ~qsd_bus.clr_err_i);
        end
    end

    assign qsd_bus.step_o       = r_step;
    assign qsd_bus.dir_o        = r_dir;
    assign qsd_bus.err_o        = r_err;
    assign qsd_bus.err_sticky_o = r_sticky;
    assign qsd_bus.ab_o         = w_new;

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - scoreboard bench for quad_step_decoder with a cycle-history reference model
module tb_quad_step_decoder;

    localparam int S = 2;
    localparam int L = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    logic a_i    = 1'b0;
    logic b_i    = 1'b0;

    quad_step_decoder_if qsd_bus ();

    quad_step_decoder #(
        .SYNC_STAGES (S),
        .FILTER_LEN  (L)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .a_i     (a_i),
        .b_i     (b_i),
        .qsd_bus (qsd_bus)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_steps  = 0;
    int lim_count = 0;

    typedef struct {
        int       cyc;
        bit       is_err;
        bit       dir;
        bit [1:0] ab;
    } exp_t;

    exp_t sb[$];
    bit   ha[$];
    bit   hb[$];
    bit       m_fa, m_fb, m_dir;
    bit [1:0] m_new, m_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Position of a state in the forward cycle 00,10,11,01
    function automatic int pos(input bit [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Raw sample k edges back; anything older than reset reads as 0
    function automatic bit hist(input bit q[$], input int k);
        int i;
        i = q.size() - 1 - k;
        return (i >= 0) ? q[i] : 1'b0;
    endfunction

    task automatic model_reset();
        ha.delete();
        hb.delete();
        m_fa = 0; m_fb = 0; m_dir = 1;
        m_new = 2'b00; m_prev = 2'b00;
    endtask

    // Reference: a level is accepted once it has been seen on the raw pin for L cycles,
    // S cycles ago; the decode reports on the state accepted one edge earlier.
    task automatic model_edge(input bit a, input bit b, input bit en);
        bit acc_a, acc_b, have_ev, ev_err;
        int d;
        exp_t e;
        ha.push_back(a);
        hb.push_back(b);
        acc_a = 1; acc_b = 1;
        for (int k = S; k < S + L; k++) begin
            if (hist(ha, k) == m_fa) acc_a = 0;
            if (hist(hb, k) == m_fb) acc_b = 0;
        end
        have_ev = 0; ev_err = 0;
        if (en && m_new != m_prev) begin
            d = (pos(m_new) - pos(m_prev) + 4) % 4;
            have_ev = 1;
            if (d == 2) ev_err = 1;
            else m_dir = (d == 1);
        end
        m_prev = m_new;
        if (acc_a) m_fa = !m_fa;
        if (acc_b) m_fb = !m_fb;
        m_new = {m_fa, m_fb};
        if (have_ev) begin
            e.cyc = cyc; e.is_err = ev_err; e.dir = m_dir; e.ab = m_new;
            sb.push_back(e);
        end
    endtask

    // Called at a negedge; drives, lets one active edge pass, returns at the next negedge
    task automatic tick(input bit a, input bit b, input bit en, input bit clr);
        a_i = a; b_i = b; qsd_bus.en_i = en; qsd_bus.clr_err_i = clr;
        @(posedge clk_i);
        model_edge(a, b, en);
        @(negedge clk_i);
    endtask

    task automatic seg(input bit a, input bit b, input bit en, input int n);
        repeat (n) tick(a, b, en, 1'b0);
    endtask

    task automatic reset_pulse(input int n);
        rst_ni = 1'b0;
        #1;
        check("rst_step_o", qsd_bus.step_o, 0);
        check("rst_err_o", qsd_bus.err_o, 0);
        check("rst_err_sticky_o", qsd_bus.err_sticky_o, 0);
        check("rst_dir_o", qsd_bus.dir_o, 1);
        check("rst_ab_o", qsd_bus.ab_o, 0);
        repeat (n) begin
            @(posedge clk_i);
            model_reset();
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes step_o or err_o
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            while (sb.size() > 0 && sb[0].cyc < cyc - 1) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_event: nothing seen, required %s at cycle %0d",
                         sb[0].is_err ? "err_o" : "step_o", sb[0].cyc + 1);
                void'(sb.pop_front());
            end
            if (qsd_bus.step_o === 1'b1 || qsd_bus.err_o === 1'b1) begin
                if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
                    e = sb.pop_front();
                    check("sb_step_o", qsd_bus.step_o, {31'd0, !e.is_err});
                    check("sb_err_o", qsd_bus.err_o, {31'd0, e.is_err});
                    check("sb_dir_o", qsd_bus.dir_o, {31'd0, e.dir});
                    check("sb_ab_o", qsd_bus.ab_o, {30'd0, e.ab});
                    if (e.is_err) check("sb_err_sticky_o", qsd_bus.err_sticky_o, 1);
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: step_o=%0b err_o=%0b at cycle %0d, required none",
                             qsd_bus.step_o, qsd_bus.err_o, cyc);
                end
                if (qsd_bus.step_o === 1'b1) begin
                    n_steps++;
                    if (qsd_bus.dir_o) lim_count = (lim_count == 7) ? 0 : lim_count + 1;
                    else               lim_count = (lim_count == 0) ? 7 : lim_count - 1;
                end
            end
        end
    end

    initial begin
        int base;
        bit [1:0] st [4];
        int p, r, len;
        bit en;
        st[0] = 2'b00; st[1] = 2'b10; st[2] = 2'b11; st[3] = 2'b01;
        qsd_bus.en_i = 1'b1;
        qsd_bus.clr_err_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        reset_pulse(2);

        // Forward sequence
        base = n_steps;
        seg(1, 0, 1, 20); seg(1, 1, 1, 20); seg(0, 1, 1, 20); seg(0, 0, 1, 20);
        check("fwd_step_count", n_steps - base, 4);
        check("fwd_ab_end", qsd_bus.ab_o, 0);

        // Reverse sequence into a wrapping 0..7 counter starting at 0
        lim_count = 0;
        base = n_steps;
        seg(0, 1, 1, 20); seg(1, 1, 1, 20); seg(1, 0, 1, 20); seg(0, 0, 1, 20);
        check("rev_step_count", n_steps - base, 4);
        check("rev_limit_count", lim_count, 4);

        // Glitches: 3 cycles rejected, 4 cycles accepted and undone
        base = n_steps;
        seg(1, 0, 1, 3); seg(0, 0, 1, 20);
        check("glitch3_steps", n_steps - base, 0);
        seg(1, 0, 1, 4); seg(0, 0, 1, 20);
        check("pulse4_steps", n_steps - base, 2);

        // Double transition 00->11 and sticky clear
        base = n_steps;
        seg(1, 1, 1, 20);
        check("jump_sticky_set", qsd_bus.err_sticky_o, 1);
        check("jump_no_step", n_steps - base, 0);
        tick(1, 1, 1, 1);
        check("jump_sticky_clr", qsd_bus.err_sticky_o, 0);
        seg(1, 0, 1, 20);
        seg(0, 0, 1, 20);

        // Disabled stepping, re-enable while stationary, then a live edge
        base = n_steps;
        seg(1, 0, 0, 20); seg(1, 1, 0, 20); seg(1, 1, 1, 20);
        check("disabled_steps", n_steps - base, 0);
        seg(0, 1, 1, 20);
        check("reenable_steps", n_steps - base, 1);
        check("reenable_dir", qsd_bus.dir_o, 1);
        seg(0, 0, 1, 20);

        // Reset with the A filter counter part-way
        seg(1, 0, 1, 4);
        reset_pulse(2);
        base = n_steps;
        seg(1, 0, 1, 12);
        check("post_rst_steps", n_steps - base, 1);
        check("post_rst_dir", qsd_bus.dir_o, 1);
        check("post_rst_ab", qsd_bus.ab_o, 2);
        seg(0, 0, 1, 12);

        // Randomised walk: neighbours, jumps, holds, short glitches, enable and clear toggling
        p = 0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      p = (p + 1) % 4;
            else if (r <= 6) p = (p + 3) % 4;
            else if (r == 7) p = (p + 2) % 4;
            len = $urandom_range(1, 12);
            en = ($urandom_range(0, 7) != 0);
            repeat (len) tick(st[p][1], st[p][0], en, ($urandom_range(0, 15) == 0));
        end
        seg(st[p][1], st[p][0], 1, 20);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
